// File: rtl/mem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, access size codes,
// the decoded memory control word and the alignment-fault helper.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic [1:0] size;
        logic       sign;
    } mem_ctrl_t;

    // Size code 11 is never a legal access, whatever the address.
    function automatic logic isFault(input logic [1:0] addrLow, input logic [1:0] size);
        case (size)
            SZ_B:    isFault = 1'b0;
            SZ_H:    isFault = addrLow[0];
            SZ_W:    isFault = (addrLow != 2'b00);
            default: isFault = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Word-wide request/grant/response bus between the LSU (master) and the
// data memory or peripheral fabric (slave).
interface mem_lsu_if;

    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busBe;
    logic        busGnt;
    logic        busRvalid;
    logic [31:0] busRdata;

    modport master (
        output busReq, busWe, busAddr, busWdata, busBe,
        input  busGnt, busRvalid, busRdata
    );

    modport slave (
        input  busReq, busWe, busAddr, busWdata, busBe,
        output busGnt, busRvalid, busRdata
    );

endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables and lane-replicated store data on the
// way out, lane extraction plus sign/zero extension of load data on the way back.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]  i_addrLow,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_writeData,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_rdAddrLow,
    input  logic [1:0]  i_rdSize,
    input  logic        i_rdSign,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_writeData;
        case (i_size)
            SZ_B: begin
                o_be    = 4'b0001 << i_addrLow;
                o_wdata = {4{i_writeData[7:0]}};
            end
            SZ_H: begin
                o_be    = 4'b0011 << {i_addrLow[1], 1'b0};
                o_wdata = {2{i_writeData[15:0]}};
            end
            SZ_W: begin
                o_be    = 4'b1111;
                o_wdata = i_writeData;
            end
            default: ;
        endcase
    end

    // sign = 0 means sign-extend, so the lane MSB is masked only for zero-extension.
    always_comb begin
        w_byte     = i_rdata[{i_rdAddrLow, 3'b000} +: 8];
        w_half     = i_rdAddrLow[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_loadData = i_rdata;
        case (i_rdSize)
            SZ_B:    o_loadData = {{24{w_byte[7] & ~i_rdSign}}, w_byte};
            SZ_H:    o_loadData = {{16{w_half[15] & ~i_rdSign}}, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: alignment check, bus request/grant/response
// sequencing and pipeline stall. Define LSU_TIMEOUT_EN to enable the bus timeout.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_writeData,
    input  mem_ctrl_t   i_ctrlMEM,
    output logic        o_stall,
    output logic [31:0] o_readData,
    output logic        o_rdValid,
    output logic        o_misaligned,
    output logic        o_busErr,
    mem_lsu_if.master   bus
);

    lsu_state_t  r_state;
    logic        r_busReq;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [31:0] r_busWdata;
    logic [3:0]  r_busBe;
    logic        r_isRead;
    logic [1:0]  r_size;
    logic        r_sign;
    logic [1:0]  r_addrLow;
    logic [31:0] r_readData;
    logic        r_rdValid;

    logic        w_access;
    logic        w_fault;
    logic        w_legal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_loadData;

    assign w_access = i_valid & (i_ctrlMEM.memRead | i_ctrlMEM.memWrite);
    assign w_fault  = isFault(i_addr[1:0], i_ctrlMEM.size);
    assign w_legal  = w_access & ~w_fault;

    assign o_stall      = (r_state == REQ) || (r_state == WAIT) || ((r_state == IDLE) && w_legal);
    assign o_misaligned = (r_state == IDLE) && w_access && w_fault;

    mem_lsu_align u_align (
        .i_addrLow   (i_addr[1:0]),
        .i_size      (i_ctrlMEM.size),
        .i_writeData (i_writeData),
        .o_be        (w_be),
        .o_wdata     (w_wdata),
        .i_rdAddrLow (r_addrLow),
        .i_rdSize    (r_size),
        .i_rdSign    (r_sign),
        .i_rdata     (bus.busRdata),
        .o_loadData  (w_loadData)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_count;
    logic             r_busErr;
    logic             w_timeout;

    // Counter is zero outside REQ/WAIT, so it starts from zero on every new request.
    always_ff @(posedge i_clk) begin
        if (i_reset || !((r_state == REQ) || (r_state == WAIT)))
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    assign w_timeout = ((r_state == REQ) || (r_state == WAIT)) &&
                       (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign o_busErr  = r_busErr;
`else
    assign o_busErr = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_busReq   <= 1'b0;
            r_busWe    <= 1'b0;
            r_busAddr  <= '0;
            r_busWdata <= '0;
            r_busBe    <= 4'b0000;
            r_isRead   <= 1'b0;
            r_size     <= SZ_B;
            r_sign     <= 1'b0;
            r_addrLow  <= 2'b00;
            r_readData <= '0;
            r_rdValid  <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_busErr   <= 1'b0;
`endif
        end else begin
            r_rdValid <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            r_busErr  <= 1'b0;
            // A grant or response arriving on the last allowed cycle still completes normally.
            if (w_timeout && !(((r_state == REQ) && bus.busGnt) ||
                               ((r_state == WAIT) && bus.busRvalid))) begin
                r_state    <= DONE;
                r_busReq   <= 1'b0;
                r_busErr   <= 1'b1;
                r_readData <= '0;
            end else
`endif
            case (r_state)
                IDLE: begin
                    if (w_legal) begin
                        r_state    <= REQ;
                        r_busReq   <= 1'b1;
                        r_busWe    <= i_ctrlMEM.memWrite;
                        r_busAddr  <= {i_addr[31:2], 2'b00};
                        r_busWdata <= w_wdata;
                        r_busBe    <= w_be;
                        r_isRead   <= ~i_ctrlMEM.memWrite;
                        r_size     <= i_ctrlMEM.size;
                        r_sign     <= i_ctrlMEM.sign;
                        r_addrLow  <= i_addr[1:0];
                    end
                end
                REQ: begin
                    if (bus.busGnt) begin
                        r_busReq <= 1'b0;
                        r_state  <= r_isRead ? WAIT : DONE;
                    end
                end
                WAIT: begin
                    if (bus.busRvalid) begin
                        r_readData <= w_loadData;
                        r_rdValid  <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busReq   = r_busReq;
    assign bus.busWe    = r_busWe;
    assign bus.busAddr  = r_busAddr;
    assign bus.busWdata = r_busWdata;
    assign bus.busBe    = r_busBe;
    assign o_readData   = r_readData;
    assign o_rdValid    = r_rdValid;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu: stores, loads with extension,
// grant back-pressure, faults, timeout (or indefinite wait) and mid-access reset.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] writeData;
    mem_ctrl_t   ctrl;
    logic        stall;
    logic [31:0] readData;
    logic        rdValid;
    logic        misaligned;
    logic        busErr;

    int checks = 0;
    int errors = 0;

    mem_lsu_if bus ();

    mem_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk        (clock),
        .i_reset      (reset),
        .i_valid      (valid),
        .i_addr       (addr),
        .i_writeData  (writeData),
        .i_ctrlMEM    (ctrl),
        .o_stall      (stall),
        .o_readData   (readData),
        .o_rdValid    (rdValid),
        .o_misaligned (misaligned),
        .o_busErr     (busErr),
        .bus          (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] rdata;
        logic [31:0] expData;
        logic [3:0]  expBe;
        int          waitCycles;
    } loadVec_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        logic [31:0] expWdata;
        logic [3:0]  expBe;
        int          gntDelay;
    } storeVec_t;

    typedef struct {
        logic        valid;
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic        expMis;
    } faultVec_t;

    loadVec_t  loads[6];
    storeVec_t stores[4];
    faultVec_t faults[6];
    logic [31:0] lastRead;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic waitCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] a, input logic [31:0] wd);
        valid         = v;
        ctrl.memRead  = rd;
        ctrl.memWrite = wr;
        ctrl.size     = sz;
        ctrl.sign     = sg;
        addr          = a;
        writeData     = wd;
        #1;
    endtask

    task automatic doStore(input storeVec_t s);
        applyStimulus(1'b1, 1'b0, 1'b1, s.size, 1'b0, s.addr, s.data);
        checkOutput("st_accept_stall", 32'(stall), 32'd1);
        waitCycle();
        for (int d = 0; d <= s.gntDelay; d++) begin
            checkOutput("st_req", 32'(bus.busReq), 32'd1);
            checkOutput("st_we", 32'(bus.busWe), 32'd1);
            checkOutput("st_addr", bus.busAddr, {s.addr[31:2], 2'b00});
            checkOutput("st_be", 32'(bus.busBe), 32'(s.expBe));
            checkOutput("st_wdata", bus.busWdata, s.expWdata);
            checkOutput("st_req_stall", 32'(stall), 32'd1);
            if (d == s.gntDelay) bus.busGnt = 1'b1;
            waitCycle();
        end
        bus.busGnt = 1'b0;
        #1;
        checkOutput("st_done_req", 32'(bus.busReq), 32'd0);
        checkOutput("st_done_stall", 32'(stall), 32'd0);
        checkOutput("st_done_rdvalid", 32'(rdValid), 32'd0);
        valid = 1'b0;
        waitCycle();
    endtask

    task automatic doLoad(input loadVec_t l);
        applyStimulus(1'b1, 1'b1, 1'b0, l.size, l.sign, l.addr, 32'h0);
        checkOutput("ld_accept_stall", 32'(stall), 32'd1);
        waitCycle();
        checkOutput("ld_req", 32'(bus.busReq), 32'd1);
        checkOutput("ld_we", 32'(bus.busWe), 32'd0);
        checkOutput("ld_addr", bus.busAddr, {l.addr[31:2], 2'b00});
        checkOutput("ld_be", 32'(bus.busBe), 32'(l.expBe));
        bus.busGnt = 1'b1;
        waitCycle();
        bus.busGnt = 1'b0;
        for (int w = 1; w <= l.waitCycles; w++) begin
            checkOutput("ld_wait_stall", 32'(stall), 32'd1);
            checkOutput("ld_wait_req", 32'(bus.busReq), 32'd0);
            checkOutput("ld_wait_rdvalid", 32'(rdValid), 32'd0);
            if (w == l.waitCycles) begin
                bus.busRvalid = 1'b1;
                bus.busRdata  = l.rdata;
            end
            waitCycle();
        end
        bus.busRvalid = 1'b0;
        bus.busRdata  = 32'h0;
        #1;
        checkOutput("ld_done_rdvalid", 32'(rdValid), 32'd1);
        checkOutput("ld_done_data", readData, l.expData);
        checkOutput("ld_done_stall", 32'(stall), 32'd0);
        valid = 1'b0;
        waitCycle();
        checkOutput("ld_idle_rdvalid", 32'(rdValid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired, simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        loads[0] = '{32'h203, SZ_B, 1'b0, 32'h80FFFFFF, 32'hFFFFFF80, 4'b1000, 3};
        loads[1] = '{32'h203, SZ_B, 1'b1, 32'h80FFFFFF, 32'h00000080, 4'b1000, 1};
        loads[2] = '{32'h102, SZ_H, 1'b0, 32'h80017FFF, 32'hFFFF8001, 4'b1100, 1};
        loads[3] = '{32'h100, SZ_H, 1'b1, 32'h1234F00D, 32'h0000F00D, 4'b0011, 2};
        loads[4] = '{32'h201, SZ_B, 1'b0, 32'h00003C00, 32'h0000003C, 4'b0010, 1};
        loads[5] = '{32'h204, SZ_W, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 2};

        stores[0] = '{32'h100, SZ_W, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 0};
        stores[1] = '{32'h102, SZ_H, 32'hABCD1234, 32'h12341234, 4'b1100, 5};
        stores[2] = '{32'h201, SZ_B, 32'h0000005A, 32'h5A5A5A5A, 4'b0010, 1};
        stores[3] = '{32'h100, SZ_H, 32'h00008765, 32'h87658765, 4'b0011, 0};

        faults[0] = '{1'b1, 1'b1, 1'b0, SZ_W,  32'h101, 1'b1};
        faults[1] = '{1'b1, 1'b1, 1'b0, 2'b11, 32'h100, 1'b1};
        faults[2] = '{1'b1, 1'b0, 1'b1, SZ_W,  32'h102, 1'b1};
        faults[3] = '{1'b1, 1'b1, 1'b0, SZ_H,  32'h101, 1'b1};
        faults[4] = '{1'b0, 1'b1, 1'b0, SZ_W,  32'h101, 1'b0};
        faults[5] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h103, 1'b0};

        reset         = 1'b1;
        bus.busGnt    = 1'b0;
        bus.busRvalid = 1'b0;
        bus.busRdata  = 32'h0;
        applyStimulus(1'b0, 1'b0, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0);
        waitCycle();
        waitCycle();
        checkOutput("rst_req", 32'(bus.busReq), 32'd0);
        checkOutput("rst_we", 32'(bus.busWe), 32'd0);
        checkOutput("rst_addr", bus.busAddr, 32'h0);
        checkOutput("rst_wdata", bus.busWdata, 32'h0);
        checkOutput("rst_be", 32'(bus.busBe), 32'd0);
        checkOutput("rst_rdata", readData, 32'h0);
        checkOutput("rst_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("rst_buserr", 32'(busErr), 32'd0);
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_mis", 32'(misaligned), 32'd0);
        reset = 1'b0;
        waitCycle();

        foreach (stores[i]) doStore(stores[i]);
        foreach (loads[i]) doLoad(loads[i]);
        lastRead = loads[5].expData;

        // Response with no outstanding read must not produce load data.
        bus.busRvalid = 1'b1;
        bus.busRdata  = 32'hFFFFFFFF;
        waitCycle();
        bus.busRvalid = 1'b0;
        #1;
        checkOutput("stray_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("stray_rdata", readData, lastRead);

        foreach (faults[i]) begin
            applyStimulus(faults[i].valid, faults[i].rd, faults[i].wr, faults[i].size, 1'b0,
                          faults[i].addr, 32'h0);
            checkOutput("fault_mis", 32'(misaligned), 32'(faults[i].expMis));
            checkOutput("fault_stall", 32'(stall), 32'd0);
            waitCycle();
            checkOutput("fault_req", 32'(bus.busReq), 32'd0);
        end
        valid = 1'b0;
        waitCycle();

        applyStimulus(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h300, 32'h0);
        waitCycle();
        bus.busGnt = 1'b1;
        waitCycle();
        bus.busGnt = 1'b0;
`ifdef LSU_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            checkOutput("to_stall", 32'(stall), 32'd1);
            checkOutput("to_buserr_early", 32'(busErr), 32'd0);
            if (c < 8) waitCycle();
        end
        waitCycle();
        checkOutput("to_buserr", 32'(busErr), 32'd1);
        checkOutput("to_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("to_rdata", readData, 32'h0);
        checkOutput("to_stall_done", 32'(stall), 32'd0);
        valid         = 1'b0;
        bus.busRvalid = 1'b1;
        bus.busRdata  = 32'h99999999;
        waitCycle();
        bus.busRvalid = 1'b0;
        #1;
        checkOutput("to_buserr_pulse", 32'(busErr), 32'd0);
        checkOutput("to_stray_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("to_stray_rdata", readData, 32'h0);
`else
        for (int c = 0; c < 20; c++) begin
            checkOutput("nto_stall", 32'(stall), 32'd1);
            checkOutput("nto_buserr", 32'(busErr), 32'd0);
            checkOutput("nto_rdvalid", 32'(rdValid), 32'd0);
            waitCycle();
        end
        bus.busRvalid = 1'b1;
        bus.busRdata  = 32'h11223344;
        waitCycle();
        bus.busRvalid = 1'b0;
        #1;
        checkOutput("nto_rdvalid_done", 32'(rdValid), 32'd1);
        checkOutput("nto_rdata", readData, 32'h11223344);
        valid = 1'b0;
        waitCycle();
`endif

        // Reset while a load is waiting for its response.
        applyStimulus(1'b1, 1'b1, 1'b0, SZ_W, 1'b0, 32'h400, 32'h0);
        waitCycle();
        bus.busGnt = 1'b1;
        waitCycle();
        bus.busGnt = 1'b0;
        checkOutput("rw_in_wait", 32'(stall), 32'd1);
        reset         = 1'b1;
        bus.busRvalid = 1'b1;
        bus.busRdata  = 32'h55555555;
        waitCycle();
        bus.busRvalid = 1'b0;
        valid         = 1'b0;
        #1;
        checkOutput("rw_req", 32'(bus.busReq), 32'd0);
        checkOutput("rw_addr", bus.busAddr, 32'h0);
        checkOutput("rw_wdata", bus.busWdata, 32'h0);
        checkOutput("rw_be", 32'(bus.busBe), 32'd0);
        checkOutput("rw_rdata", readData, 32'h0);
        checkOutput("rw_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("rw_stall", 32'(stall), 32'd0);
        reset = 1'b0;
        waitCycle();
        checkOutput("rw_after_rdvalid", 32'(rdValid), 32'd0);
        checkOutput("rw_after_rdata", readData, 32'h0);

        doStore(stores[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator for the MEM stage. Takes one decoded memory access per instruction, does the alignment checks, and drives a word-wide request/grant/response bus toward a data memory or peripheral fabric. It stalls the pipeline until the access completes, then returns sign- or zero-extended load data. The ready/valid bus decouples the core from memory latency.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 256: bus cycles allowed from request to completion before an error is forced. Only used with the timeout macro.

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_reset  in  1  reset, synchronous, active-high
- i_valid  in  1  MEM-stage instruction valid
- i_addr  in  32  byte address
- i_writeData  in  32  store data, right-justified
- i_ctrlMEM  in  mem_ctrl_t  fields: memRead, memWrite, size (00 = B, 01 = H, 10 = W, 11 = invalid), sign (0 = sign-extend, 1 = zero-extend)
- o_stall  out  1  freezes the pipeline upstream of MEM
- o_readData  out  32  extended load data
- o_rdValid  out  1  one-cycle pulse; o_readData is valid
- o_misaligned  out  1  access fault; no bus traffic is issued
- o_busErr  out  1  one-cycle pulse; access timed out
- o_busReq  out  1  bus request valid
- o_busWe  out  1  1 = write
- o_busAddr  out  32  word address; bits [1:0] are always 00
- o_busWdata  out  32  store data replicated into the addressed lanes
- o_busBe  out  4  byte enables
- i_busGnt  in  1  request accepted in this cycle
- i_busRvalid  in  1  read data valid
- i_busRdata  in  32  read word

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - An access is i_valid & (memRead | memWrite).
  - Fault conditions: size = 11, H with addr[0] = 1, or W with addr[1:0] ≠ 00. A faulting access sets o_misaligned = 1 combinationally, issues no request and does not stall.
  - A legal access registers the address, control, byte-enables and lane-replicated data, then moves to REQ.
- REQ:
  - o_busReq = 1; all bus outputs are held stable until i_busGnt.
  - On grant: a write goes to DONE (posted); a read goes to WAIT.
- WAIT: on i_busRvalid, latch i_busRdata and go to DONE.
- DONE:
  - o_stall = 0 and o_rdValid = 1 for a read.
  - Next state is IDLE; the access in the following cycle is evaluated from IDLE.
- o_stall = (state ∈ {REQ, WAIT}) | (IDLE & legal access).
- The pipeline holds i_* stable while o_stall = 1.
- Byte enables by size:
  - B: 0001 << addr[1:0]
  - H: 0011 << {addr[1], 0}
  - W: 1111
- Write data by size:
  - B: i_writeData[7:0] replicated ×4
  - H: [15:0] replicated ×2
  - W: as is
- Read extraction:
  - Select the byte or halfword lane by registered addr[1:0].
  - Extend with the lane MSB when sign = 0, with zeros when sign = 1.
- An i_busRvalid outside WAIT is ignored.

## Timing
- Reset values:
  - State = IDLE.
  - o_busReq, o_busWe, o_rdValid, o_busErr = 0.
  - o_busAddr, o_busWdata, o_readData = 0; o_busBe = 0000.
- o_stall and o_misaligned are combinational and are 0 in reset when i_valid = 0.
- Minimum latency:
  - Store: accept cycle C, REQ at C+1, grant at C+1, DONE at C+2. Total 2 stall cycles.
  - Load: grant at C+1, rvalid at C+2, DONE at C+3 with o_rdValid.
- Grant and rvalid in the same cycle while in REQ is illegal for this bus; rvalid is only sampled in WAIT.
- Reset asserted mid-access: return to IDLE next edge, drop o_busReq, discard any in-flight response.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A counter clears on entering REQ and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT_CYCLES - 1: go to DONE, pulse o_busErr, force o_readData = 0, no o_rdValid.
- Undefined: no counter, o_busErr is tied to 0, and the LSU waits indefinitely.

## Structure
- Shared package holds:
  - lsu_state_t enum (IDLE, REQ, WAIT, DONE).
  - Size encodings SZ_B, SZ_H, SZ_W.
  - The existing mem_ctrl_t.
- Sub-module mem_lsu_align, purely combinational:
  - Byte-enable and write-lane generation.
  - Load lane extraction and extension.

## Test plan
- SW 0xDEADBEEF @0x100, grant on first REQ cycle:
  - o_busAddr = 0x100, o_busBe = 1111, o_busWdata = 0xDEADBEEF.
  - o_stall high for 2 cycles.
- LB @0x203, sign = 0, rdata 0x80FFFFFF after 3 wait cycles:
  - o_busBe = 1000.
  - o_readData = 0xFFFFFF80 with o_rdValid at DONE.
  - The same access with sign = 1 gives 0x00000080.
- SH 0x1234 @0x102:
  - o_busBe = 1100, o_busWdata = 0x12341234.
  - Grant withheld 5 cycles; address and data stay stable throughout.
- LW @0x101 and size = 11:
  - o_misaligned = 1, o_busReq never asserts, o_stall = 0.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES = 8, load with no rvalid:
  - o_busErr pulses after the 8th REQ/WAIT cycle, o_rdValid stays 0.
  - A stray rvalid arriving afterwards is ignored.
- Reset asserted in WAIT: next cycle IDLE, o_busReq = 0, all registered outputs 0.
